// File: rtl/render_scan_ctrl_if.sv
// Raster coordinate stream between render_scan_ctrl and its consumers
// (full_renderer and the frame buffer writer).
interface render_scan_ctrl_if;
  logic [10:0] hcount_axis_tdata;
  logic [9:0]  vcount_axis_tdata;
  logic        axis_tvalid;
  logic        axis_tready;
  logic        axis_tlast;

  modport master (
    output hcount_axis_tdata,
    output vcount_axis_tdata,
    output axis_tvalid,
    output axis_tlast,
    input  axis_tready
  );

  modport slave (
    input  hcount_axis_tdata,
    input  vcount_axis_tdata,
    input  axis_tvalid,
    input  axis_tlast,
    output axis_tready
  );
endinterface

// File: rtl/render_scan_ctrl.sv
// Frame-coherent raster coordinate source: snapshots the scene on a frame
// trigger, then streams (hcount, vcount) beats over a valid/ready channel.
module render_scan_ctrl #(
  parameter int START_X  = 390,
  parameter int START_Y  = 390,
  parameter int END_X    = 634,
  parameter int END_Y    = 765,
  parameter int SCENE_W  = 2112,
  parameter bit FREE_RUN = 1'b0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_trigger_in,
  input  logic [SCENE_W-1:0] scene_in,
  render_scan_ctrl_if.master axis,
  output logic [SCENE_W-1:0] scene_out,
  output logic               frame_start_out,
  output logic               frame_done_out,
  output logic               busy_out,
  output logic [7:0]         frame_count_out,
  output logic               overrun_out
);

  localparam logic [10:0] FIRST_X = 11'(START_X);
  localparam logic [10:0] LAST_X  = 11'(END_X - 1);
  localparam logic [9:0]  FIRST_Y = 10'(START_Y);
  localparam logic [9:0]  LAST_Y  = 10'(END_Y - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_q, state_d;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        start_d, done_d, overrun_d, load_scene;
  logic [7:0]  count_d;
  logic        go, xfer, at_last_col, at_last_row;

  assign go          = frame_trigger_in | FREE_RUN;
  assign at_last_col = (h_q == LAST_X);
  assign at_last_row = (v_q == LAST_Y);
  assign xfer        = (state_q == SCAN) & axis.axis_tready;

  // Valid is a pure function of state, so it never looks at tready.
  assign axis.axis_tvalid       = (state_q == SCAN);
  assign axis.axis_tlast        = (state_q == SCAN) & at_last_col;
  assign axis.hcount_axis_tdata = h_q;
  assign axis.vcount_axis_tdata = v_q;
  assign busy_out               = (state_q == SCAN);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    load_scene = 1'b0;
    count_d    = frame_count_out;
    overrun_d  = overrun_out;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = SCAN;
          start_d    = 1'b1;
          load_scene = 1'b1;
        end
      end
      SCAN: begin
        // Any request arriving mid-frame, including the final beat, is lost.
        if (frame_trigger_in & ~FREE_RUN) overrun_d = 1'b1;
        if (xfer) begin
          if (at_last_col) begin
            h_d = FIRST_X;
            if (at_last_row) begin
              v_d     = FIRST_Y;
              state_d = IDLE;
              done_d  = 1'b1;
              count_d = frame_count_out + 8'd1;
            end else begin
              v_d = v_q + 10'd1;
            end
          end else begin
            h_d = h_q + 11'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      h_q             <= FIRST_X;
      v_q             <= FIRST_Y;
      frame_start_out <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_count_out <= 8'd0;
      overrun_out     <= 1'b0;
    end else begin
      state_q         <= state_d;
      h_q             <= h_d;
      v_q             <= v_d;
      frame_start_out <= start_d;
      frame_done_out  <= done_d;
      frame_count_out <= count_d;
      overrun_out     <= overrun_d;
    end
  end

  // NOTE: the wide scene snapshot is reset too, so consumers see a defined
  // zero scene before the first frame rather than power-up garbage.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      scene_out <= '0;
    end else if (load_scene) begin
      scene_out <= scene_in;
    end
  end

endmodule

// File: tb/tb_render_scan_ctrl.sv
// Self-checking bench for render_scan_ctrl: three configurations (4x3 region,
// 1-column region, 1x1 free-running) compared every cycle against a frame model.
module tb_render_scan_ctrl;
  localparam int SW = 32;
  localparam int SX [3] = '{0, 5, 7};
  localparam int SY [3] = '{0, 2, 9};
  localparam int EX [3] = '{4, 6, 8};
  localparam int EY [3] = '{3, 5, 10};
  localparam bit FR [3] = '{1'b0, 1'b0, 1'b1};
  localparam logic [SW-1:0] SCENE_A = 32'hAAAA_0004;
  localparam logic [SW-1:0] SCENE_B = 32'hBBBB_0004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_v   [3];
  logic          trig_v  [3];
  logic          rdy_v   [3];
  logic [SW-1:0] scene_v [3];
  logic [SW-1:0] sc_o    [3];
  logic          st_o    [3];
  logic          dn_o    [3];
  logic          bs_o    [3];
  logic [7:0]    cnt_o   [3];
  logic          ov_o    [3];

  render_scan_ctrl_if ax_a ();
  render_scan_ctrl_if ax_c ();
  render_scan_ctrl_if ax_f ();
  assign ax_a.axis_tready = rdy_v[0];
  assign ax_c.axis_tready = rdy_v[1];
  assign ax_f.axis_tready = rdy_v[2];

  render_scan_ctrl #(.START_X(SX[0]), .START_Y(SY[0]), .END_X(EX[0]), .END_Y(EY[0]),
                     .SCENE_W(SW), .FREE_RUN(FR[0])) dut_a (
    .clk_in(clk), .rst_in(rst_v[0]), .frame_trigger_in(trig_v[0]), .scene_in(scene_v[0]),
    .axis(ax_a), .scene_out(sc_o[0]), .frame_start_out(st_o[0]), .frame_done_out(dn_o[0]),
    .busy_out(bs_o[0]), .frame_count_out(cnt_o[0]), .overrun_out(ov_o[0]));

  render_scan_ctrl #(.START_X(SX[1]), .START_Y(SY[1]), .END_X(EX[1]), .END_Y(EY[1]),
                     .SCENE_W(SW), .FREE_RUN(FR[1])) dut_c (
    .clk_in(clk), .rst_in(rst_v[1]), .frame_trigger_in(trig_v[1]), .scene_in(scene_v[1]),
    .axis(ax_c), .scene_out(sc_o[1]), .frame_start_out(st_o[1]), .frame_done_out(dn_o[1]),
    .busy_out(bs_o[1]), .frame_count_out(cnt_o[1]), .overrun_out(ov_o[1]));

  render_scan_ctrl #(.START_X(SX[2]), .START_Y(SY[2]), .END_X(EX[2]), .END_Y(EY[2]),
                     .SCENE_W(SW), .FREE_RUN(FR[2])) dut_f (
    .clk_in(clk), .rst_in(rst_v[2]), .frame_trigger_in(trig_v[2]), .scene_in(scene_v[2]),
    .axis(ax_f), .scene_out(sc_o[2]), .frame_start_out(st_o[2]), .frame_done_out(dn_o[2]),
    .busy_out(bs_o[2]), .frame_count_out(cnt_o[2]), .overrun_out(ov_o[2]));

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is an index 0..W*H-1 into the raster, advanced on each
  // accepted beat; coordinates follow from the index by plain division.
  bit            m_busy  [3];
  int            m_idx   [3];
  logic [SW-1:0] m_scene [3];
  bit            m_start [3];
  bit            m_done  [3];
  int            m_count [3];
  bit            m_ovr   [3];

  task automatic model_step(input int k);
    int n;
    n = (EX[k] - SX[k]) * (EY[k] - SY[k]);
    if (rst_v[k]) begin
      m_busy[k] = 1'b0; m_idx[k] = 0; m_scene[k] = '0;
      m_start[k] = 1'b0; m_done[k] = 1'b0; m_count[k] = 0; m_ovr[k] = 1'b0;
    end else begin
      m_start[k] = 1'b0;
      m_done[k]  = 1'b0;
      if (!m_busy[k]) begin
        if (trig_v[k] || FR[k]) begin
          m_busy[k] = 1'b1; m_idx[k] = 0; m_scene[k] = scene_v[k]; m_start[k] = 1'b1;
        end
      end else begin
        if (trig_v[k] && !FR[k]) m_ovr[k] = 1'b1;
        if (rdy_v[k]) begin
          if (m_idx[k] == n - 1) begin
            m_busy[k] = 1'b0; m_idx[k] = 0; m_done[k] = 1'b1;
            m_count[k] = (m_count[k] + 1) % 256;
          end else begin
            m_idx[k]++;
          end
        end
      end
    end
  endtask

  always @(posedge clk) for (int k = 0; k < 3; k++) model_step(k);

  task automatic cmp_outs(input int k, input string tag, input logic vld, input logic [10:0] h,
                          input logic [9:0] v, input logic last);
    int w, eh, ev;
    w  = EX[k] - SX[k];
    eh = SX[k] + m_idx[k] % w;
    ev = SY[k] + m_idx[k] / w;
    check({tag, "_tvalid"}, 64'(vld), 64'(m_busy[k]));
    check({tag, "_hcount"}, 64'(h), 64'(eh));
    check({tag, "_vcount"}, 64'(v), 64'(ev));
    check({tag, "_tlast"},  64'(last), 64'(m_busy[k] && eh == EX[k] - 1));
    check({tag, "_scene"},  64'(sc_o[k]), 64'(m_scene[k]));
    check({tag, "_start"},  64'(st_o[k]), 64'(m_start[k]));
    check({tag, "_done"},   64'(dn_o[k]), 64'(m_done[k]));
    check({tag, "_busy"},   64'(bs_o[k]), 64'(m_busy[k]));
    check({tag, "_count"},  64'(cnt_o[k]), 64'(m_count[k]));
    check({tag, "_overrun"}, 64'(ov_o[k]), 64'(m_ovr[k]));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_outs(0, "a", ax_a.axis_tvalid, ax_a.hcount_axis_tdata, ax_a.vcount_axis_tdata, ax_a.axis_tlast);
      cmp_outs(1, "c", ax_c.axis_tvalid, ax_c.hcount_axis_tdata, ax_c.vcount_axis_tdata, ax_c.axis_tlast);
      cmp_outs(2, "f", ax_f.axis_tvalid, ax_f.hcount_axis_tdata, ax_f.vcount_axis_tdata, ax_f.axis_tlast);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives dut_a's tready until frame_done_out, recording transfers in order.
  task automatic run_a(input bit rnd, input int first, input bit retrig,
                       output int beats, output int lasts, output int gap, output bit in_order);
    int last_c, done_c;
    last_c = -100; done_c = -1;
    beats = first; lasts = 0; in_order = 1'b1;
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      if (dn_o[0]) done_c = c;
      trig_v[0] = retrig && dn_o[0];
      rdy_v[0]  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ax_a.axis_tvalid && rdy_v[0]) begin
        if (ax_a.hcount_axis_tdata != 11'(beats % 4) || ax_a.vcount_axis_tdata != 10'(beats / 4))
          in_order = 1'b0;
        if (ax_a.axis_tlast) lasts++;
        beats++;
        last_c = c;
      end
      tick();
    end
    trig_v[0] = 1'b0;
    rdy_v[0]  = 1'b1;
    gap = (done_c < 0) ? -1 : done_c - last_c;
  endtask

  initial begin
    int beats, lasts, gap, dones, prev, bad, cnt260, bad_c;
    bit ok, found;

    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1; trig_v[k] = 1'b0; rdy_v[k] = 1'b1; scene_v[k] = '0;
    end
    trig_v[0]  = 1'b1;
    scene_v[0] = 32'hDEAD_BEEF;
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_tvalid", 64'(ax_a.axis_tvalid), 64'd0);
    check("rst_hcount", 64'(ax_a.hcount_axis_tdata), 64'd0);
    check("rst_scene",  64'(sc_o[0]), 64'd0);
    check("rst_start",  64'(st_o[0]), 64'd0);
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
    trig_v[0] = 1'b0;
    tick();
    check("rst_trig_ignored", 64'(ax_a.axis_tvalid), 64'd0);

    // Single frame at full throughput.
    scene_v[0] = 32'h1111_0002;
    trig_v[0] = 1'b1; tick(); trig_v[0] = 1'b0;
    check("t2_first_valid", 64'(ax_a.axis_tvalid), 64'd1);
    check("t2_first_start", 64'(st_o[0]), 64'd1);
    check("t2_first_h", 64'(ax_a.hcount_axis_tdata), 64'd0);
    check("t2_first_v", 64'(ax_a.vcount_axis_tdata), 64'd0);
    run_a(1'b0, 0, 1'b0, beats, lasts, gap, ok);
    check("t2_beats", 64'(beats), 64'd12);
    check("t2_tlasts", 64'(lasts), 64'd3);
    check("t2_done_gap", 64'(gap), 64'd1);
    check("t2_order", 64'(ok), 64'd1);
    check("t2_count", 64'(cnt_o[0]), 64'd1);

    // Random back-pressure.
    trig_v[0] = 1'b1; tick(); trig_v[0] = 1'b0;
    run_a(1'b1, 0, 1'b0, beats, lasts, gap, ok);
    check("t3_beats", 64'(beats), 64'd12);
    check("t3_order", 64'(ok), 64'd1);
    check("t3_tlasts", 64'(lasts), 64'd3);
    check("t3_count", 64'(cnt_o[0]), 64'd2);

    // Scene coherence, mid-frame trigger, trigger in the done cycle.
    scene_v[0] = SCENE_A;
    trig_v[0] = 1'b1; tick(); trig_v[0] = 1'b0;
    tick();
    scene_v[0] = SCENE_B;
    trig_v[0] = 1'b1; tick(); trig_v[0] = 1'b0;
    run_a(1'b0, 2, 1'b0, beats, lasts, gap, ok);
    check("t4_beats", 64'(beats), 64'd12);
    check("t4_scene_a", 64'(sc_o[0]), 64'(SCENE_A));
    check("t4_overrun", 64'(ov_o[0]), 64'd1);
    trig_v[0] = 1'b1; tick(); trig_v[0] = 1'b0;
    check("t4_scene_b", 64'(sc_o[0]), 64'(SCENE_B));
    run_a(1'b0, 0, 1'b1, beats, lasts, gap, ok);
    check("t4_retrig_valid", 64'(ax_a.axis_tvalid), 64'd1);
    check("t4_retrig_start", 64'(st_o[0]), 64'd1);
    run_a(1'b0, 0, 1'b0, beats, lasts, gap, ok);
    check("t4_retrig_beats", 64'(beats), 64'd12);
    check("t4_count", 64'(cnt_o[0]), 64'd5);

    // Reset in the middle of a frame.
    trig_v[0] = 1'b1; tick(); trig_v[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (ax_a.axis_tvalid && ax_a.hcount_axis_tdata == 11'd1 && ax_a.vcount_axis_tdata == 10'd1)
        found = 1'b1;
      else
        tick();
    end
    check("t5_reach_beat5", 64'(found), 64'd1);
    rst_v[0] = 1'b1; tick(); rst_v[0] = 1'b0;
    check("t5_tvalid", 64'(ax_a.axis_tvalid), 64'd0);
    check("t5_count", 64'(cnt_o[0]), 64'd0);
    tick();
    check("t5_no_done", 64'(dn_o[0]), 64'd0);
    trig_v[0] = 1'b1; tick(); trig_v[0] = 1'b0;
    check("t5_restart_h", 64'(ax_a.hcount_axis_tdata), 64'd0);
    check("t5_restart_v", 64'(ax_a.vcount_axis_tdata), 64'd0);
    run_a(1'b0, 0, 1'b0, beats, lasts, gap, ok);
    check("t5_beats", 64'(beats), 64'd12);
    check("t5_count_after", 64'(cnt_o[0]), 64'd1);

    // Randomized soak on all three instances; the per-cycle model does the checking.
    bad_c = 0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++) begin
        trig_v[k]  = ($urandom_range(0, 11) == 0);
        rdy_v[k]   = 1'($urandom_range(0, 1));
        scene_v[k] = $urandom;
        rst_v[k]   = ($urandom_range(0, 299) == 0);
      end
      tick();
      if (ax_c.axis_tvalid && !ax_c.axis_tlast) bad_c++;
    end
    check("soak_col_tlast", 64'(bad_c), 64'd0);
    for (int k = 0; k < 3; k++) begin
      trig_v[k] = 1'b0; rdy_v[k] = 1'b1; rst_v[k] = 1'b0;
    end

    // Free-running 1x1: one beat cycle plus one idle cycle per frame.
    rst_v[2] = 1'b1; tick(); rst_v[2] = 1'b0;
    dones = 0; prev = -1; bad = 0; cnt260 = -1;
    for (int c = 0; c < 2000 && dones < 260; c++) begin
      trig_v[2] = 1'($urandom_range(0, 1));
      tick();
      if (dn_o[2]) begin
        if (prev >= 0 && c - prev != 2) bad++;
        prev = c;
        dones++;
        if (dones == 260) cnt260 = int'(cnt_o[2]);
      end
    end
    trig_v[2] = 1'b0;
    check("t6_dones", 64'(dones), 64'd260);
    check("t6_period", 64'(bad), 64'd0);
    check("t6_count_wrap", 64'(cnt260), 64'd4);
    check("t6_overrun", 64'(ov_o[2]), 64'd0);

    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
